// File: rtl/sdio_block_sequencer.sv
// rtl/sdio_block_sequencer.sv - CMD53 block sequencer driving the SDIO data PHY
// One PHY activation per block; handles block counting, gaps, write-CRC stop, abort and timeout.
module sdio_block_sequencer #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_write_flag,
  input  logic        i_block_mode,
  input  logic [11:0] i_block_size,
  input  logic [8:0]  i_block_count,
  input  logic [8:0]  i_byte_count,
  input  logic        i_abort,
  output logic        o_phy_activate,
  output logic        o_phy_write_flag,
  output logic [12:0] o_phy_data_count,
  input  logic        i_phy_finished,
  input  logic        i_phy_crc_good,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_crc_error,
  output logic        o_timeout,
  output logic        o_aborted,
  output logic [8:0]  o_blocks_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVATE, S_WAIT_FIN, S_RELEASE, S_GAP, S_DONE
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic          write_q;
  logic [8:0]    total_blocks;
  logic          last_block;
  logic          stop_now;

  // total_blocks == 0 is the infinite case and never terminates on count
  assign last_block = (total_blocks != 9'd0) && (o_blocks_done == total_blocks);
  assign stop_now   = o_crc_error | o_timeout | o_aborted | i_abort | last_block;
  assign o_busy     = (state != S_IDLE);
  assign o_done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (i_start) state_next = S_ACTIVATE;
      S_ACTIVATE: state_next = i_abort ? S_RELEASE : S_WAIT_FIN;
      S_WAIT_FIN: if (i_phy_finished || i_abort || tmo_cnt == TW'(1)) state_next = S_RELEASE;
      S_RELEASE:  if (!i_phy_finished) state_next = stop_now ? S_DONE : S_GAP;
      S_GAP: begin
        if (i_abort)                state_next = S_RELEASE;
        else if (gap_cnt == GW'(0)) state_next = S_ACTIVATE;
      end
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_phy_activate   <= 1'b0;
      o_phy_write_flag <= 1'b0;
      o_phy_data_count <= 13'd0;
      o_crc_error      <= 1'b0;
      o_timeout        <= 1'b0;
      o_aborted        <= 1'b0;
      o_blocks_done    <= 9'd0;
      tmo_cnt          <= '0;
      gap_cnt          <= '0;
      write_q          <= 1'b0;
      total_blocks     <= 9'd0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          write_q       <= i_write_flag;
          total_blocks  <= i_block_mode ? i_block_count : 9'd1;
          o_blocks_done <= 9'd0;
          o_crc_error   <= 1'b0;
          o_timeout     <= 1'b0;
          o_aborted     <= 1'b0;
          if (i_block_mode)              o_phy_data_count <= {1'b0, i_block_size};
          else if (i_byte_count == 9'd0) o_phy_data_count <= 13'd512;
          else                           o_phy_data_count <= {4'd0, i_byte_count};
        end
        S_ACTIVATE: begin
          if (i_abort) begin
            o_aborted <= 1'b1;
          end else begin
            o_phy_activate   <= 1'b1;
            o_phy_write_flag <= write_q;
            tmo_cnt          <= TW'(TIMEOUT_CYCLES);
          end
        end
        S_WAIT_FIN: begin
          tmo_cnt <= tmo_cnt - TW'(1);
          if (i_abort) o_aborted <= 1'b1;
          // finished wins over timeout in the same cycle; the block still counts under abort
          if (i_phy_finished) begin
            o_phy_activate <= 1'b0;
            o_blocks_done  <= o_blocks_done + 9'd1;
            if (write_q && !i_phy_crc_good) o_crc_error <= 1'b1;
          end else if (i_abort) begin
            o_phy_activate <= 1'b0;
          end else if (tmo_cnt == TW'(1)) begin
            o_phy_activate <= 1'b0;
            o_timeout      <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (i_abort) o_aborted <= 1'b1;
          gap_cnt <= GW'(GAP_CYCLES - 1);
        end
        S_GAP: begin
          if (i_abort) o_aborted <= 1'b1;
          gap_cnt <= gap_cnt - GW'(1);
        end
        S_DONE: o_phy_write_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_block_sequencer.sv
// tb/tb_sdio_block_sequencer.sv - directed self-checking bench for sdio_block_sequencer
module tb_sdio_block_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start_t = 1'b0;
  logic        write_flag = 1'b0, block_mode = 1'b0;
  logic [11:0] block_size = 12'd0;
  logic [8:0]  block_count = 9'd0, byte_count = 9'd0;
  logic        abort = 1'b0, fin = 1'b0, fin_t = 1'b0, crc = 1'b0;

  logic        act, pwf, busy, done, crc_err, tmo, abrt;
  logic [12:0] pdc;
  logic [8:0]  bdone;
  logic        act_t, pwf_t, busy_t, done_t, crc_err_t, tmo_t, abrt_t;
  logic [12:0] pdc_t;
  logic [8:0]  bdone_t;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sdio_block_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_write_flag(write_flag),
    .i_block_mode(block_mode), .i_block_size(block_size), .i_block_count(block_count),
    .i_byte_count(byte_count), .i_abort(abort), .o_phy_activate(act),
    .o_phy_write_flag(pwf), .o_phy_data_count(pdc), .i_phy_finished(fin),
    .i_phy_crc_good(crc), .o_busy(busy), .o_done(done), .o_crc_error(crc_err),
    .o_timeout(tmo), .o_aborted(abrt), .o_blocks_done(bdone)
  );

  sdio_block_sequencer #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(100)) dut_t (
    .clk(clk), .rst_n(rst_n), .i_start(start_t), .i_write_flag(write_flag),
    .i_block_mode(block_mode), .i_block_size(block_size), .i_block_count(block_count),
    .i_byte_count(byte_count), .i_abort(abort), .o_phy_activate(act_t),
    .o_phy_write_flag(pwf_t), .o_phy_data_count(pdc_t), .i_phy_finished(fin_t),
    .i_phy_crc_good(crc), .o_busy(busy_t), .o_done(done_t), .o_crc_error(crc_err_t),
    .o_timeout(tmo_t), .o_aborted(abrt_t), .o_blocks_done(bdone_t)
  );

  // Monitor: activate rises, finished-to-activate latency, done pulses
  int   cyc = 0, fin_cyc = -1, act_rises = 0, done_cnt = 0, done_t_cnt = 0;
  int   last_lat = 0, lat_bad = 0;
  logic act_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (act && !act_prev) begin
      act_rises++;
      if (fin_cyc >= 0) begin
        last_lat = cyc - fin_cyc;
        if (last_lat < 4) lat_bad++;
      end
    end
    act_prev = act;
    if (fin) fin_cyc = cyc;
    if (done) done_cnt++;
    if (done_t) done_t_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_xfer(input logic wr, input logic bm, input logic [11:0] bs,
                            input logic [8:0] bc, input logic [8:0] byc);
    @(negedge clk);
    write_flag = wr; block_mode = bm; block_size = bs; block_count = bc; byte_count = byc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_act();
    int n = 0;
    while (act !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("wait_activate", 32'(n < 2000), 1);
  endtask

  task automatic phy_block(input int dly, input logic good);
    wait_act();
    repeat (dly) @(negedge clk);
    fin = 1'b1; crc = good;
    @(negedge clk);
    fin = 1'b0; crc = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("wait_idle", 32'(n < 100), 1);
  endtask

  int r_act, r_done, r_lat, n;

  initial begin
    #12;
    chk("rst_act", act, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pdc", pdc, 0);
    chk("rst_bdone", bdone, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // byte-mode read, byte_count 0 -> 512, slow PHY
    r_act = act_rises; r_done = done_cnt;
    start_xfer(1'b0, 1'b0, 12'd0, 9'd0, 9'd0);
    chk("t1_busy", busy, 1);
    chk("t1_pdc", pdc, 512);
    phy_block(600, 1'b0);
    wait_idle();
    chk("t1_bdone", bdone, 1);
    chk("t1_done", done_cnt - r_done, 1);
    chk("t1_acts", act_rises - r_act, 1);
    chk("t1_flags", {crc_err, tmo, abrt}, 0);

    // block write 64 x 3, good CRC
    r_act = act_rises; r_done = done_cnt; r_lat = lat_bad;
    start_xfer(1'b1, 1'b1, 12'd64, 9'd3, 9'd0);
    chk("t2_pdc", pdc, 64);
    phy_block(5, 1'b1);
    chk("t2_pwf", pwf, 1);
    phy_block(5, 1'b1);
    phy_block(5, 1'b1);
    wait_idle();
    repeat (10) @(negedge clk);
    chk("t2_acts", act_rises - r_act, 3);
    chk("t2_bdone", bdone, 3);
    chk("t2_done", done_cnt - r_done, 1);
    chk("t2_gap_min", lat_bad - r_lat, 0);
    chk("t2_gap_last", last_lat, 4);
    chk("t2_crc", crc_err, 0);
    chk("t2_pwf_clr", pwf, 0);

    // block write x4, bad CRC on block 2
    r_act = act_rises; r_done = done_cnt;
    start_xfer(1'b1, 1'b1, 12'd64, 9'd4, 9'd0);
    phy_block(3, 1'b1);
    phy_block(3, 1'b0);
    wait_idle();
    repeat (20) @(negedge clk);
    chk("t3_acts", act_rises - r_act, 2);
    chk("t3_bdone", bdone, 2);
    chk("t3_crc", crc_err, 1);
    chk("t3_done", done_cnt - r_done, 1);

    // infinite mode, abort in 5th block's WAIT_FIN
    r_done = done_cnt;
    start_xfer(1'b0, 1'b1, 12'd32, 9'd0, 9'd0);
    chk("t4_crc_clr", crc_err, 0);
    repeat (4) phy_block(3, 1'b1);
    wait_act();
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_act_drop", act, 0);
    wait_idle();
    chk("t4_abrt", abrt, 1);
    chk("t4_bdone", bdone, 4);
    chk("t4_done", done_cnt - r_done, 1);

    // abort coincident with finished on 5th block
    r_done = done_cnt;
    start_xfer(1'b0, 1'b1, 12'd32, 9'd0, 9'd0);
    repeat (4) phy_block(3, 1'b1);
    wait_act();
    repeat (2) @(negedge clk);
    fin = 1'b1; crc = 1'b1; abort = 1'b1;
    @(negedge clk);
    fin = 1'b0; crc = 1'b0; abort = 1'b0;
    wait_idle();
    chk("t4b_abrt", abrt, 1);
    chk("t4b_bdone", bdone, 5);
    chk("t4b_done", done_cnt - r_done, 1);

    // timeout instance: PHY never finishes
    @(negedge clk);
    block_mode = 1'b0; byte_count = 9'd16; write_flag = 1'b0; start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    n = 0;
    while (act_t !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t5_act_rise", 32'(n < 20), 1);
    n = 0;
    while (act_t === 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("t5_act_len", n, 100);
    chk("t5_tmo", tmo_t, 1);
    repeat (5) @(negedge clk);
    chk("t5_idle", busy_t, 0);
    chk("t5_bdone", bdone_t, 0);
    chk("t5_done", done_t_cnt, 1);

    // async reset mid-WAIT_FIN
    r_done = done_cnt;
    start_xfer(1'b1, 1'b1, 12'd64, 9'd2, 9'd0);
    wait_act();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_act", act, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pwf", pwf, 0);
    chk("t6_pdc", pdc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_nodone", done_cnt - r_done, 0);

    // restart, with a stray start while busy
    r_act = act_rises; r_done = done_cnt;
    start_xfer(1'b1, 1'b1, 12'd64, 9'd2, 9'd0);
    @(negedge clk);
    block_size = 12'd100; block_count = 9'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    phy_block(3, 1'b1);
    chk("t7_pdc", pdc, 64);
    phy_block(3, 1'b1);
    wait_idle();
    repeat (10) @(negedge clk);
    chk("t7_bdone", bdone, 2);
    chk("t7_acts", act_rises - r_act, 2);
    chk("t7_done", done_cnt - r_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
